// File: rtl/fix_tx_arbiter.sv
// fix_tx_arbiter
// Shares the single FIX header encoder between all payload sources
// (logon, heartbeat, resend, sequence-reset/reject, logout, order).
// One requester is chosen, its payload is latched and handed to the
// encoder, and the arbiter waits for enc_done before advancing the
// outgoing MsgSeqNum and keeping a copy of the payload for resend.
// It also owns the heartbeat idle timer that drives hb_request.
//
// Arbitration: urgent requesters (URGENT_MASK) always beat non-urgent
// ones and are served lowest-index first. Non-urgent requesters share
// a round-robin pointer that only ever rests on non-urgent indices.

module fix_tx_arbiter #(
    parameter int                 FIX_PAYLOAD_LEN = 220,
    parameter int                 NUM_REQ         = 6,
    parameter logic [NUM_REQ-1:0] URGENT_MASK     = 6'b000011,
    parameter int                 HB_INTERVAL     = 10000000,
    parameter int                 ENC_TIMEOUT     = 64
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_REQ-1:0]                   req,
    input  logic [NUM_REQ*FIX_PAYLOAD_LEN*8-1:0] req_payload,
    output logic [NUM_REQ-1:0]                   grant,
    input  logic                                 enc_ready,
    output logic                                 enc_valid,
    output logic [FIX_PAYLOAD_LEN*8-1:0]         enc_payload,
    input  logic                                 enc_done,
    input  logic                                 seq_load,
    input  logic [31:0]                          seq_load_value,
    output logic [31:0]                          tx_seq_num,
    output logic [FIX_PAYLOAD_LEN*8-1:0]         last_payload,
    output logic                                 hb_request,
    output logic                                 busy,
    output logic                                 timeout_err
);

    localparam int                 PAYLOAD_W   = FIX_PAYLOAD_LEN * 8;
    localparam int                 IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int                 TO_W        = $clog2(ENC_TIMEOUT + 1);
    localparam logic [NUM_REQ-1:0] NORMAL_MASK = ~URGENT_MASK;
    localparam logic [31:0]        HB_LIMIT    = 32'(HB_INTERVAL);
    localparam logic [TO_W-1:0]    TO_LAST     = TO_W'(ENC_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t               state;
    logic [IDX_W-1:0]     rr_ptr;
    logic [TO_W-1:0]      to_cnt;
    logic [31:0]          hb_timer;

    logic [NUM_REQ-1:0]   urgent_req;
    logic [NUM_REQ-1:0]   normal_req;
    logic                 urgent_hit;
    logic [IDX_W-1:0]     urgent_idx;
    logic                 normal_hit;
    logic [IDX_W-1:0]     normal_idx;
    logic [IDX_W-1:0]     ptr_after;
    logic                 pick_valid;
    logic [IDX_W-1:0]     pick_idx;
    logic [NUM_REQ-1:0]   pick_onehot;
    logic [PAYLOAD_W-1:0] pick_payload;
    logic                 done_hit;

    assign urgent_req = req & URGENT_MASK;
    assign normal_req = req & NORMAL_MASK;

    // Urgent class: fixed priority, the lowest requesting index wins.
    always_comb begin
        urgent_hit = 1'b0;
        urgent_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (urgent_req[i]) begin
                urgent_hit = 1'b1;
                urgent_idx = IDX_W'(i);
            end
        end
    end

    // Non-urgent class: first requester found scanning upward from rr_ptr.
    always_comb begin
        normal_hit = |normal_req;
        normal_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (normal_req[(int'(rr_ptr) + k) % NUM_REQ]) begin
                normal_idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    // Pointer after a non-urgent grant: next index past the winner that is not urgent.
    always_comb begin
        ptr_after = rr_ptr;
        for (int s = NUM_REQ; s >= 1; s--) begin
            if (NORMAL_MASK[(int'(normal_idx) + s) % NUM_REQ]) begin
                ptr_after = IDX_W'((int'(normal_idx) + s) % NUM_REQ);
            end
        end
    end

    assign pick_valid   = urgent_hit | normal_hit;
    assign pick_idx     = urgent_hit ? urgent_idx : normal_idx;
    assign pick_onehot  = NUM_REQ'(1) << pick_idx;
    assign pick_payload = req_payload[int'(pick_idx) * PAYLOAD_W +: PAYLOAD_W];

    // enc_done only counts while a message is outstanding.
    assign done_hit = (state == WAIT) && enc_done;

    // Issue/wait sequencer: captures the winner, strobes the encoder, waits for done or timeout.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            grant        <= '0;
            enc_valid    <= 1'b0;
            enc_payload  <= '0;
            last_payload <= '0;
            busy         <= 1'b0;
            timeout_err  <= 1'b0;
            rr_ptr       <= '0;
            to_cnt       <= '0;
        end else begin
            grant       <= '0;
            enc_valid   <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (enc_ready && pick_valid) begin
                        state       <= ISSUE;
                        busy        <= 1'b1;
                        grant       <= pick_onehot;
                        enc_valid   <= 1'b1;
                        enc_payload <= pick_payload;
                        if (!urgent_hit) begin
                            rr_ptr <= ptr_after;
                        end
                    end
                end
                ISSUE: begin
                    state  <= WAIT;
                    to_cnt <= '0;
                end
                WAIT: begin
                    if (enc_done) begin
                        state        <= IDLE;
                        busy         <= 1'b0;
                        last_payload <= enc_payload;
                    end else if (to_cnt == TO_LAST) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Outgoing MsgSeqNum: an explicit load overrides the post-message increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_seq_num <= 32'd1;
        end else if (seq_load) begin
            tx_seq_num <= seq_load_value;
        end else if (done_hit) begin
            tx_seq_num <= tx_seq_num + 32'd1;
        end
    end

    // Heartbeat idle timer: saturates at the interval and holds hb_request until a message completes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hb_timer   <= '0;
            hb_request <= 1'b0;
        end else if (done_hit) begin
            hb_timer   <= '0;
            hb_request <= 1'b0;
        end else if (hb_timer == HB_LIMIT) begin
            hb_request <= 1'b1;
        end else begin
            hb_timer   <= hb_timer + 32'd1;
            hb_request <= ((hb_timer + 32'd1) == HB_LIMIT);
        end
    end

endmodule
